// File: rtl/qea_state_dump_if.sv
// Amplitude stream bundle: valid/ready with data, index and last.
// master drives valid/data/index/last; slave drives ready.
interface qea_state_dump_if #(
  parameter int DATA_W  = 64,
  parameter int INDEX_W = 18
);
  logic               valid;
  logic               ready;
  logic [DATA_W-1:0]  data;
  logic [INDEX_W-1:0] index;
  logic               last;

  modport master (
    output valid, data, index, last,
    input  ready
  );

  modport slave (
    input  valid, data, index, last,
    output ready
  );
endinterface

// File: rtl/qea_state_dump.sv
// QEA state-RAM readback: sweeps rows, unpacks lanes, streams amplitudes.
// Ports: clk/rst, i_start/i_qbit_num, o_state_* RAM port, amp stream, status.
module qea_state_dump #(
  parameter int PE_NUM_WIDTH     = 2,
  parameter int PE_NUM           = 4,
  parameter int DATA_WIDTH       = 32,
  parameter int STATE_DATA_WIDTH = 64,
  parameter int STATE_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH   = 6,
  parameter int RD_LATENCY       = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_start,
  input  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num,
  output logic [PE_NUM-1:0]                  o_state_ena,
  output logic [PE_NUM-1:0]                  o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]        o_state_addra,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0] i_state_dout,
  qea_state_dump_if.master                   amp,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_error
);
  localparam int AW  = STATE_ADDR_WIDTH;
  localparam int PNW = PE_NUM_WIDTH;
  localparam int QW  = MAX_QBIT_WIDTH;
  localparam int SDW = STATE_DATA_WIDTH;
  localparam int IW  = AW + PNW;
  localparam int RW  = PE_NUM * SDW;
  localparam logic [QW-1:0] NMin = QW'(PNW);
  localparam logic [QW-1:0] NMax = QW'(AW + PNW);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [QW-1:0]   n_q, n_d;
  logic [AW-1:0]   row_q, row_d;
  logic            all_iss_q, all_iss_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic [RW-1:0]   rowbuf_q [2];
  logic [RW-1:0]   rowbuf_d [2];
  logic            hd_q, hd_d;
  logic            tl_q, tl_d;
  logic [1:0]      fill_q, fill_d;
  logic [PNW-1:0]  beat_q, beat_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            err_q, err_d;

  logic            n_ok;
  logic            running;
  logic [AW-1:0]   row_last;
  logic [IW-1:0]   idx_last;
  logic [2:0]      inflight;
  logic [2:0]      occ;
  logic            issue;
  logic            valid;
  logic            hs;
  logic            pop;
  logic            cap;
  logic [SDW-1:0]  lane;

  always_comb begin
    n_ok     = (i_qbit_num >= NMin) && (i_qbit_num <= NMax);
    running  = (state_q == S_RUN);
    row_last = ~({AW{1'b1}} << (n_q - NMin));
    idx_last = ~({IW{1'b1}} << n_q);
    // Slots are counted as filled buffers plus reads still in the pipe,
    // so a buffer freed this cycle is only reusable next cycle.
    inflight = '0;
    for (int k = 0; k < RD_LATENCY; k++) begin
      inflight = inflight + {2'b00, pipe_q[k]};
    end
    occ   = inflight + {1'b0, fill_q};
    issue = running && !all_iss_q && (occ < 3'd2);
    valid = running && (fill_q != 2'd0);
    hs    = valid && amp.ready;
    pop   = hs && (beat_q == PNW'(PE_NUM - 1));
    cap   = pipe_q[RD_LATENCY-1];
    // Lane 0 sits in the most significant slice of the row.
    lane = '0;
    for (int j = 0; j < PE_NUM; j++) begin
      if (beat_q == PNW'(j)) begin
        lane = rowbuf_q[hd_q][(PE_NUM-1-j)*SDW +: SDW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    row_d     = row_q;
    all_iss_d = all_iss_q;
    addr_d    = addr_q;
    rowbuf_d  = rowbuf_q;
    hd_d      = hd_q;
    tl_d      = tl_q;
    fill_d    = fill_q;
    beat_d    = beat_q;
    idx_d     = idx_q;
    err_d     = 1'b0;
    pipe_d    = pipe_q << 1;
    pipe_d[0] = issue;

    unique case (1'b1)
      state_q == S_IDLE: begin
        if (i_start && n_ok) begin
          state_d   = S_RUN;
          n_d       = i_qbit_num;
          row_d     = '0;
          all_iss_d = 1'b0;
          hd_d      = 1'b0;
          tl_d      = 1'b0;
          fill_d    = '0;
          beat_d    = '0;
          idx_d     = '0;
        end else if (i_start) begin
          err_d = 1'b1;
        end
      end
      state_q == S_RUN: begin
        if (issue) begin
          addr_d = row_q;
          row_d  = row_q + AW'(1);
          if (row_q == row_last) begin
            all_iss_d = 1'b1;
          end
        end
        if (cap) begin
          rowbuf_d[tl_q] = i_state_dout;
          tl_d           = ~tl_q;
        end
        fill_d = fill_q + {1'b0, cap} - {1'b0, pop};
        if (hs) begin
          idx_d  = idx_q + IW'(1);
          beat_d = beat_q + PNW'(1);
        end
        if (pop) begin
          hd_d = ~hd_q;
        end
        if (hs && amp.last) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      row_q     <= '0;
      all_iss_q <= 1'b0;
      addr_q    <= '0;
      pipe_q    <= '0;
      rowbuf_q  <= '{default: '0};
      hd_q      <= 1'b0;
      tl_q      <= 1'b0;
      fill_q    <= '0;
      beat_q    <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      row_q     <= row_d;
      all_iss_q <= all_iss_d;
      addr_q    <= addr_d;
      pipe_q    <= pipe_d;
      rowbuf_q  <= rowbuf_d;
      hd_q      <= hd_d;
      tl_q      <= tl_d;
      fill_q    <= fill_d;
      beat_q    <= beat_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
    end
  end

  assign o_state_ena   = {PE_NUM{issue}};
  assign o_state_wea   = '0;
  assign o_state_addra = issue ? row_q : addr_q;
  assign o_busy        = running;
  assign o_done        = (state_q == S_DONE);
  assign o_error       = err_q;

  // Amplitude is {real, imag}.
  assign amp.valid = valid;
  assign amp.data  = {lane[DATA_WIDTH +: DATA_WIDTH], lane[0 +: DATA_WIDTH]};
  assign amp.index = idx_q;
  assign amp.last  = valid && (idx_q == idx_last);
endmodule
